// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start detect, mid-bit sampling, parity and stop check.
// Ports:
//   Clk         in   system clock, rising edge
//   Rst         in   asynchronous active-high reset
//   Rx_In       in   asynchronous serial line, idle high
//   Rx_Data     out  payload of the last good frame
//   Data_Rdy    out  one-cycle strobe, Rx_Data/Parity_Err valid
//   Parity_Err  out  parity of the last delivered frame was wrong
//   Framing_Err out  stop bit of the last completed frame was low
//   Rx_Busy     out  receiver is not idle
module uart_rx_deframer #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx_In,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Data_Rdy,
    output logic                 Parity_Err,
    output logic                 Framing_Err,
    output logic                 Rx_Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic          PAR_ON   = (PARITY_EN != 0);
    localparam logic          PAR_ODD  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        clk_cnt;
    logic [CW-1:0]        cnt_nxt;
    logic [IW-1:0]        bit_idx;
    logic [IW-1:0]        idx_nxt;
    logic                 sync_q;
    logic                 rx_s;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 bit_end;
    logic                 shift_en;
    logic                 par_en;
    logic                 deliver;
    logic                 frame_bad;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync_q <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_q <= Rx_In;
            rx_s   <= sync_q;
        end
    end

    assign bit_end = (clk_cnt == CNT_END);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            Rx_Busy <= 1'b0;
        end else begin
            state   <= state_nxt;
            clk_cnt <= cnt_nxt;
            bit_idx <= idx_nxt;
            Rx_Busy <= (state_nxt != S_IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = clk_cnt + CW'(1);
        idx_nxt   = bit_idx;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        deliver   = 1'b0;
        frame_bad = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                // Half a bit in: confirm the start bit and align to mid-bit.
                if (clk_cnt == CNT_MID) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_nxt  = '0;
                    shift_en = 1'b1;
                    if (bit_idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = PAR_ON ? S_PARITY : S_STOP;
                    end else begin
                        idx_nxt = bit_idx + IW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    par_en    = 1'b1;
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // Leaving at the stop midpoint lets a back-to-back
                // start edge half a bit later be caught in IDLE.
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        deliver   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Line held low: wait for it to recover before hunting
                // for a new start bit.
                cnt_nxt = '0;
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                idx_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            shreg       <= '0;
            perr        <= 1'b0;
            Rx_Data     <= '0;
            Data_Rdy    <= 1'b0;
            Parity_Err  <= 1'b0;
            Framing_Err <= 1'b0;
        end else begin
            Data_Rdy <= deliver;
            if (shift_en) begin
                // LSB arrives first, so shift in at the top.
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            end
            if (par_en) begin
                perr <= PAR_ON & ((^{shreg, rx_s}) ^ PAR_ODD);
            end
            if (deliver) begin
                Rx_Data     <= shreg;
                Parity_Err  <= PAR_ON & perr;
                Framing_Err <= 1'b0;
            end
            if (frame_bad) begin
                Framing_Err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomized bench for uart_rx_deframer against a frame-level reference model.
// Drives whole serial frames and checks delivery, flags, latency and busy.
module tb_uart_rx_deframer;

    localparam int DB   = 8;
    localparam int CPB  = 16;
    localparam int PEN  = 1;
    localparam int PODD = 0;
    // Bits on the line per frame: start + data + parity + stop.
    localparam int NB   = 1 + DB + PEN + 1;
    // 2 sync stages, stop-bit midpoint on the line, 1 registered output.
    localparam int LAT  = 2 + (NB - 1) * CPB + CPB / 2 + 1;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Rx_In;
    logic [DB-1:0] Rx_Data;
    logic          Data_Rdy;
    logic          Parity_Err;
    logic          Framing_Err;
    logic          Rx_Busy;

    uart_rx_deframer #(
        .DATA_BITS   (DB),
        .CLKS_PER_BIT(CPB),
        .PARITY_EN   (PEN),
        .PARITY_ODD  (PODD)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Rx_In      (Rx_In),
        .Rx_Data    (Rx_Data),
        .Data_Rdy   (Data_Rdy),
        .Parity_Err (Parity_Err),
        .Framing_Err(Framing_Err),
        .Rx_Busy    (Rx_Busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int            c;
        logic [DB-1:0] d;
        logic          pe;
        logic          fe;
    } rec_t;

    rec_t mq[$];

    always @(negedge Clk) begin
        if (Data_Rdy === 1'b1) begin
            mq.push_back('{c: cyc, d: Rx_Data, pe: Parity_Err, fe: Framing_Err});
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [DB-1:0] exp_data;
    logic          exp_pe;
    logic          exp_fe;
    int            last_rdy;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic line(input logic v, input int n);
        repeat (n) begin
            @(negedge Clk);
            Rx_In = v;
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input bit flip,
                              input bit stop, output int c0);
        logic [NB-1:0] f;
        logic          pbit;
        pbit = logic'($countones(d) % 2) ^ logic'(PODD) ^ flip;
        f    = {stop, pbit, d, 1'b0};
        c0   = 0;
        for (int i = 0; i < NB; i++) begin
            @(negedge Clk);
            if (i == 0) c0 = cyc;
            Rx_In = f[i];
            repeat (CPB - 1) @(negedge Clk);
        end
    endtask

    task automatic model_frame(input logic [DB-1:0] d, input bit flip,
                               input bit good);
        if (good) begin
            exp_data = d;
            exp_pe   = flip;
            exp_fe   = 1'b0;
        end else begin
            exp_fe = 1'b1;
        end
    endtask

    task automatic check_frame(input string tag, input bit good,
                               input int c0);
        rec_t r;
        chk({tag, "_rdy_cnt"}, mq.size(), good ? 1 : 0);
        if (good && mq.size() > 0) begin
            r = mq.pop_front();
            last_rdy = r.c;
            chk({tag, "_lat"}, r.c - c0, LAT);
            chk({tag, "_rdy_data"}, r.d, exp_data);
            chk({tag, "_rdy_perr"}, r.pe, exp_pe);
            chk({tag, "_rdy_ferr"}, r.fe, 1'b0);
        end
        mq.delete();
        chk({tag, "_data"}, Rx_Data, exp_data);
        chk({tag, "_perr"}, Parity_Err, exp_pe);
        chk({tag, "_ferr"}, Framing_Err, exp_fe);
        chk({tag, "_busy"}, Rx_Busy, !good);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            c0;
        int            c_first;
        bit            seen;
        bit            all_busy;
        logic [DB-1:0] d;
        bit            flip;
        bit            good;
        logic [DB-1:0] abort_d;

        Rst      = 1'b1;
        Rx_In    = 1'b1;
        exp_data = '0;
        exp_pe   = 1'b0;
        exp_fe   = 1'b0;
        last_rdy = 0;
        repeat (4) @(negedge Clk);
        Rst = 1'b0;
        line(1'b1, 5);
        chk("rst_data", Rx_Data, 0);
        chk("rst_rdy", Data_Rdy, 0);
        chk("rst_perr", Parity_Err, 0);
        chk("rst_ferr", Framing_Err, 0);
        chk("rst_busy", Rx_Busy, 0);
        mq.delete();

        // Basic good frame.
        send_frame(8'hA5, 1'b0, 1'b1, c0);
        model_frame(8'hA5, 1'b0, 1'b1);
        check_frame("t1", 1'b1, c0);
        line(1'b1, 3 * CPB);

        // Short low glitch must be rejected.
        @(negedge Clk);
        Rx_In = 1'b0;
        c0    = cyc;
        seen  = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge Clk);
            if (i == 4) Rx_In = 1'b1;
            if (Rx_Busy === 1'b1) seen = 1'b1;
        end
        chk("t2_busy_seen", seen, 1'b1);
        chk("t2_busy_drop", Rx_Busy, 1'b0);
        chk("t2_no_rdy", mq.size(), 0);
        chk("t2_data", Rx_Data, exp_data);
        chk("t2_perr", Parity_Err, exp_pe);
        chk("t2_ferr", Framing_Err, exp_fe);
        line(1'b1, 2 * CPB);

        // Parity error is delivered flagged, then cleared by a clean frame.
        send_frame(8'h3C, 1'b1, 1'b1, c0);
        model_frame(8'h3C, 1'b1, 1'b1);
        check_frame("t3a", 1'b1, c0);
        line(1'b1, CPB);
        send_frame(8'h01, 1'b0, 1'b1, c0);
        model_frame(8'h01, 1'b0, 1'b1);
        check_frame("t3b", 1'b1, c0);
        line(1'b1, CPB);

        // Framing error followed by a held-low line.
        send_frame(8'h55, 1'b0, 1'b0, c0);
        model_frame(8'h55, 1'b0, 1'b0);
        check_frame("t4a", 1'b0, c0);
        all_busy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            Rx_In = 1'b0;
            if (Rx_Busy !== 1'b1) all_busy = 1'b0;
        end
        chk("t4_busy_hold", all_busy, 1'b1);
        chk("t4_hold_no_rdy", mq.size(), 0);
        line(1'b1, 2 * CPB);
        send_frame(8'h0F, 1'b0, 1'b1, c0);
        model_frame(8'h0F, 1'b0, 1'b1);
        check_frame("t4b", 1'b1, c0);
        line(1'b1, CPB);

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b0, 1'b1, c0);
        model_frame(8'h00, 1'b0, 1'b1);
        check_frame("t5a", 1'b1, c0);
        c_first = last_rdy;
        send_frame(8'hFF, 1'b0, 1'b1, c0);
        model_frame(8'hFF, 1'b0, 1'b1);
        check_frame("t5b", 1'b1, c0);
        chk("t5_gap", last_rdy - c_first, NB * CPB);
        line(1'b1, CPB);

        // Reset in the middle of data bit 3.
        abort_d = 8'h6B;
        @(negedge Clk);
        Rx_In = 1'b0;
        repeat (CPB - 1) @(negedge Clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            Rx_In = abort_d[i];
            repeat (CPB - 1) @(negedge Clk);
        end
        @(negedge Clk);
        Rx_In = abort_d[3];
        repeat (CPB / 2) @(negedge Clk);
        Rst   = 1'b1;
        Rx_In = 1'b1;
        @(negedge Clk);
        chk("t6_rst_data", Rx_Data, 0);
        chk("t6_rst_perr", Parity_Err, 0);
        chk("t6_rst_ferr", Framing_Err, 0);
        chk("t6_rst_busy", Rx_Busy, 0);
        chk("t6_rst_rdy", Data_Rdy, 0);
        repeat (2) @(negedge Clk);
        Rst      = 1'b0;
        exp_data = '0;
        exp_pe   = 1'b0;
        exp_fe   = 1'b0;
        line(1'b1, 3 * CPB);
        chk("t6_no_rdy", mq.size(), 0);
        chk("t6_idle", Rx_Busy, 0);
        send_frame(8'h81, 1'b0, 1'b1, c0);
        model_frame(8'h81, 1'b0, 1'b1);
        check_frame("t6", 1'b1, c0);
        line(1'b1, CPB);

        // Randomized frames with parity/stop errors and random gaps.
        for (int k = 0; k < 40; k++) begin
            d    = DB'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            good = ($urandom_range(0, 6) != 0);
            send_frame(d, flip, good, c0);
            model_frame(d, flip, good);
            check_frame("rnd", good, c0);
            if (good) begin
                line(1'b1, $urandom_range(0, 20));
            end else begin
                line(1'b0, $urandom_range(0, 40));
                line(1'b1, $urandom_range(2, 30));
            end
        end

        line(1'b1, 2 * CPB);
        chk("end_no_rdy", mq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
